// File: rtl/im_loader_pkg.sv
// -----------------------------------------------------------------------------
// im_loader_pkg
//   Shared constants for the instruction-memory loader:
//     - loader FSM state encodings (3-bit, plain localparams so that older
//       tools and hand-written decoders can use the same values)
//     - frame field widths
//     - small helpers for state decoding and capacity arithmetic
// -----------------------------------------------------------------------------
package im_loader_pkg;

  // Loader FSM state encodings
  localparam logic [2:0] LD_IDLE = 3'd0;
  localparam logic [2:0] LD_LEN0 = 3'd1;  // waiting for length high byte
  localparam logic [2:0] LD_LEN1 = 3'd2;  // waiting for length low byte
  localparam logic [2:0] LD_DATA = 3'd3;  // streaming 4*N data bytes
  localparam logic [2:0] LD_CSUM = 3'd4;  // waiting for XOR checksum byte
  localparam logic [2:0] LD_DONE = 3'd5;  // image verified, core released
  localparam logic [2:0] LD_ERR  = 3'd6;  // overflow or checksum mismatch

  // Frame field widths
  localparam int LEN_W  = 16;  // big-endian word count
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  // States in which the loader consumes stream bytes.
  function automatic logic is_busy_state(input logic [2:0] s);
    return (s == LD_LEN0) || (s == LD_LEN1) || (s == LD_DATA) || (s == LD_CSUM);
  endfunction

  // States from which a new load may be launched by start.
  function automatic logic is_launch_state(input logic [2:0] s);
    return (s == LD_IDLE) || (s == LD_DONE) || (s == LD_ERR);
  endfunction

  // Instruction-memory capacity in words, one bit wider than the length
  // field so that a full 16-bit count can be compared without overflow.
  function automatic logic [LEN_W:0] max_words(input int addr_w);
    return (LEN_W + 1)'(1) << addr_w;
  endfunction

endpackage

// File: rtl/im_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// im_loader_byte_packer
//   Assembles big-endian 32-bit words from a byte stream. The first byte of
//   a word ends up in bits [31:24], the fourth in [7:0].
//
//   word_o / word_valid_o are combinational: on the cycle the fourth byte is
//   presented with byte_valid_i high, word_o already holds the complete word
//   and word_valid_o pulses, so the parent can register the memory write in
//   the same edge that accepts the byte.
//
// Ports
//   clk           in   system clock
//   rst           in   asynchronous active-low reset
//   clear_i       in   drop any partial word, restart at byte 0
//   byte_valid_i  in   byte_i is accepted at this edge
//   byte_i        in   stream byte
//   word_o        out  assembled word (valid when word_valid_o)
//   word_valid_o  out  fourth byte of a word is being accepted
// -----------------------------------------------------------------------------
module im_loader_byte_packer
  import im_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              byte_valid_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;   // first three bytes of the current word

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clear_i) begin
      cnt_d   = 2'd0;
      shift_d = 24'd0;
    end else if (byte_valid_i) begin
      // counter wraps naturally from 3 back to 0 after a full word
      cnt_d   = cnt_q + 2'd1;
      shift_d = {shift_q[15:0], byte_i};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  assign word_o       = {shift_q, byte_i};
  assign word_valid_o = byte_valid_i && !clear_i && (cnt_q == 2'd3);

endmodule

// File: rtl/im_loader.sv
// -----------------------------------------------------------------------------
// im_loader
//   Receives a program image as a valid/ready byte stream and writes it into
//   the instruction memory from word 0 upward. The mips core is held in reset
//   (cpu_rst=1) until a complete image with a matching checksum is loaded.
//
//   Frame: N[15:8], N[7:0], then 4*N data bytes (big-endian words), then one
//   XOR checksum byte covering the data bytes only.
//
// Parameters
//   IM_ADDR_W     IM word-address width (capacity 2**IM_ADDR_W words, <= 16)
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-low reset
//   start         in   begin a new load (honoured in IDLE/DONE/ERR only)
//   rx_data       in   stream byte
//   rx_valid      in   rx_data valid
//   rx_ready      out  byte accepted this cycle if rx_valid
//   im_we         out  IM write strobe, one cycle per word
//   im_addr       out  IM word address
//   im_wdata      out  IM write data
//   cpu_rst       out  active-high reset to the core, low only in DONE
//   busy          out  load in progress
//   done          out  image loaded and verified (level)
//   err           out  length overflow or checksum mismatch (level)
//   words_loaded  out  words written in the current load
//
// All outputs are registers. Status outputs are loaded from the next-state
// value so that they always agree with the state register.
// -----------------------------------------------------------------------------
module im_loader
  import im_loader_pkg::*;
#(
  parameter int IM_ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 im_we,
  output logic [IM_ADDR_W-1:0] im_addr,
  output logic [31:0]          im_wdata,
  output logic                 cpu_rst,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [IM_ADDR_W:0]   words_loaded
);

  localparam logic [LEN_W:0] MAX_WORDS = max_words(IM_ADDR_W);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  logic [2:0]           state_q, state_d;
  logic [BYTE_W-1:0]    len_hi_q, len_hi_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [BYTE_W-1:0]    xor_q, xor_d;
  // words_loaded doubles as the word index of the next write
  logic [IM_ADDR_W:0]   wl_q, wl_d;

  logic                 im_we_q, im_we_d;
  logic [IM_ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [WORD_W-1:0]    im_wdata_q, im_wdata_d;
  logic                 rx_ready_q, busy_q, done_q, err_q, cpu_rst_q;

  // ---------------------------------------------------------------------------
  // Handshake and helpers
  // ---------------------------------------------------------------------------
  logic                 accept;
  logic                 start_load;
  logic                 data_byte;
  logic [LEN_W-1:0]     len_full;
  logic                 last_word;
  logic [WORD_W-1:0]    packed_word;
  logic                 packed_valid;

  // rx_ready_q is high exactly in the busy states, so it is the handshake gate.
  assign accept     = rx_valid && rx_ready_q;
  assign start_load = start && is_launch_state(state_q);
  assign data_byte  = accept && (state_q == LD_DATA);
  assign len_full   = {len_hi_q, rx_data};
  // The word completing now is the last one when index+1 reaches N.
  assign last_word  = ((LEN_W + 1)'(wl_q) + (LEN_W + 1)'(1)) == {1'b0, len_q};

  im_loader_byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (start_load),
    .byte_valid_i (data_byte),
    .byte_i       (rx_data),
    .word_o       (packed_word),
    .word_valid_o (packed_valid)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LD_IDLE, LD_DONE, LD_ERR: begin
        if (start) state_d = LD_LEN0;
      end
      LD_LEN0: begin
        if (accept) state_d = LD_LEN1;
      end
      LD_LEN1: begin
        if (accept) begin
          if ({1'b0, len_full} > MAX_WORDS) begin
            state_d = LD_ERR;
          end else if (len_full == '0) begin
            // empty image: go straight to the checksum byte
            state_d = LD_CSUM;
          end else begin
            state_d = LD_DATA;
          end
        end
      end
      LD_DATA: begin
        if (packed_valid && last_word) state_d = LD_CSUM;
      end
      LD_CSUM: begin
        if (accept) state_d = (rx_data == xor_q) ? LD_DONE : LD_ERR;
      end
      default: state_d = LD_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    xor_d      = xor_q;
    wl_d       = wl_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;

    if (start_load) begin
      len_hi_d = '0;
      len_d    = '0;
      xor_d    = '0;
      wl_d     = '0;
    end else begin
      if (accept && (state_q == LD_LEN0)) len_hi_d = rx_data;
      if (accept && (state_q == LD_LEN1)) len_d    = len_full;
      if (data_byte)                      xor_d    = xor_q ^ rx_data;
      // Word write is registered here, so the strobe, address, data and the
      // incremented count all appear together in the following cycle.
      if (packed_valid) begin
        im_we_d    = 1'b1;
        im_addr_d  = wl_q[IM_ADDR_W-1:0];
        im_wdata_d = packed_word;
        wl_d       = wl_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= LD_IDLE;
      len_hi_q   <= '0;
      len_q      <= '0;
      xor_q      <= '0;
      wl_q       <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      rx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_rst_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      xor_q      <= xor_d;
      wl_q       <= wl_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      rx_ready_q <= is_busy_state(state_d);
      busy_q     <= is_busy_state(state_d);
      done_q     <= (state_d == LD_DONE);
      err_q      <= (state_d == LD_ERR);
      cpu_rst_q  <= (state_d != LD_DONE);
    end
  end

  assign rx_ready     = rx_ready_q;
  assign im_we        = im_we_q;
  assign im_addr      = im_addr_q;
  assign im_wdata     = im_wdata_q;
  assign cpu_rst      = cpu_rst_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_im_loader.sv
// -----------------------------------------------------------------------------
// tb_im_loader
//   Drives framed program images into im_loader and compares every output on
//   every cycle against a byte-count-based model of the frame rules.
// -----------------------------------------------------------------------------
module tb_im_loader;

  localparam int AW   = 10;
  localparam int MAXW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   words_loaded;

  im_loader #(.IM_ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .cpu_rst      (cpu_rst),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: tracks how many frame bytes have been taken
  // ---------------------------------------------------------------------------
  bit          chk_en = 1'b0;
  bit          m_active = 1'b0, m_done = 1'b0, m_err = 1'b0, m_we = 1'b0;
  int          m_cnt = 0, m_n = 0, m_addr = 0, m_wl = 0;
  logic [7:0]  m_hi = 8'h00, m_xor = 8'h00;
  logic [31:0] m_word = 32'h0, m_wdata = 32'h0;

  logic [31:0] tb_mem [0:MAXW-1];
  int          we_count = 0;
  int          last_we_addr = -1;

  task automatic model_reset();
    m_active = 1'b0; m_done = 1'b0; m_err = 1'b0; m_we = 1'b0;
    m_cnt = 0; m_wl = 0; m_xor = 8'h00; m_word = 32'h0;
  endtask

  // Advances the model across the coming rising edge using the inputs that
  // the DUT will sample there.
  task automatic model_step();
    int j;
    m_we = 1'b0;
    if (!m_active) begin
      if (start) begin
        m_active = 1'b1; m_cnt = 0; m_xor = 8'h00; m_wl = 0;
        m_done = 1'b0; m_err = 1'b0; m_word = 32'h0;
      end
    end else if (rx_valid) begin
      if (m_cnt == 0) begin
        m_hi  = rx_data;
        m_cnt = 1;
      end else if (m_cnt == 1) begin
        m_n   = int'({m_hi, rx_data});
        m_cnt = 2;
        if (m_n > MAXW) begin
          m_active = 1'b0;
          m_err    = 1'b1;
        end
      end else if (m_cnt < 2 + 4 * m_n) begin
        j      = m_cnt - 2;
        m_word = {m_word[23:0], rx_data};
        m_xor  = m_xor ^ rx_data;
        if (j % 4 == 3) begin
          m_we    = 1'b1;
          m_addr  = j / 4;
          m_wdata = m_word;
          m_wl    = m_wl + 1;
        end
        m_cnt = m_cnt + 1;
      end else begin
        m_active = 1'b0;
        if (rx_data == m_xor) m_done = 1'b1;
        else                  m_err  = 1'b1;
      end
    end
  endtask

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      if (!rst) begin
        model_reset();
        check("rst_rx_ready", rx_ready, 0);
        check("rst_im_we", im_we, 0);
        check("rst_im_addr", im_addr, 0);
        check("rst_im_wdata", im_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_words_loaded", words_loaded, 0);
        check("rst_cpu_rst", cpu_rst, 1);
      end else begin
        check("rx_ready", rx_ready, m_active);
        check("busy", busy, m_active);
        check("done", done, m_done);
        check("err", err, m_err);
        check("cpu_rst", cpu_rst, !m_done);
        check("words_loaded", words_loaded, m_wl);
        check("im_we", im_we, m_we);
        if (m_we && im_we) begin
          check("im_addr", im_addr, m_addr);
          check("im_wdata", im_wdata, m_wdata);
        end
        if (im_we) begin
          tb_mem[im_addr] = im_wdata;
          we_count++;
          last_we_addr = int'(im_addr);
        end
        model_step();
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  logic [31:0] wq [$];
  logic [7:0]  fq [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] xor_words();
    logic [7:0] x = 8'h00;
    foreach (wq[i]) x = x ^ wq[i][31:24] ^ wq[i][23:16] ^ wq[i][15:8] ^ wq[i][7:0];
    return x;
  endfunction

  // csum_ovr < 0 selects the correct checksum.
  task automatic build_frame(input int n_field, input int csum_ovr);
    logic [15:0] nf;
    nf = n_field[15:0];
    fq = {};
    fq.push_back(nf[15:8]);
    fq.push_back(nf[7:0]);
    foreach (wq[i]) begin
      fq.push_back(wq[i][31:24]);
      fq.push_back(wq[i][23:16]);
      fq.push_back(wq[i][15:8]);
      fq.push_back(wq[i][7:0]);
    end
    if (csum_ovr < 0) fq.push_back(xor_words());
    else              fq.push_back(csum_ovr[7:0]);
  endtask

  // gap: 0 back-to-back, 1 one idle cycle after each byte, 2 random 0..2 idles
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = rx_ready;
    end
    check("rx_ready_wait", ok, 1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    if (gap == 1) tick();
    else if (gap == 2) repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic send_range(input int first, input int last, input int gap);
    for (int i = first; i <= last; i++) send_byte(fq[i], gap);
  endtask

  task automatic send_frame(input int gap);
    send_range(0, fq.size() - 1, gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_ref_image();
    wq = {};
    wq.push_back(32'h20080005);
    wq.push_back(32'h21090003);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    bit bad;
    int ovr;
    int gap;

    #3 rst = 1'b0;
    chk_en = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Reset in the middle of DATA
    wq = {};
    for (int i = 0; i < 3; i++) wq.push_back($urandom);
    build_frame(3, -1);
    pulse_start();
    send_range(0, 5, 0);
    rst = 1'b0;
    tick();
    check("reset_cpu_rst_low", cpu_rst, 1);
    check("reset_busy_low", busy, 0);
    tick();
    rst = 1'b1;
    tick();
    check("reset_cpu_rst_after", cpu_rst, 1);
    check("reset_words_after", words_loaded, 0);

    // Reference image, correct checksum
    load_ref_image();
    check("csum_pin", xor_words(), 8'h06);
    build_frame(2, -1);
    we_count = 0;
    pulse_start();
    send_frame(0);
    check("img_done", done, 1);
    check("img_cpu_rst", cpu_rst, 0);
    check("img_words_loaded", words_loaded, 2);
    check("img_we_count", we_count, 2);
    check("img_mem0", tb_mem[0], 32'h20080005);
    check("img_mem1", tb_mem[1], 32'h21090003);

    // Same image, wrong checksum, then a good reload from ERR
    build_frame(2, 0);
    pulse_start();
    send_frame(0);
    check("badcsum_err", err, 1);
    check("badcsum_done", done, 0);
    check("badcsum_cpu_rst", cpu_rst, 1);
    build_frame(2, -1);
    pulse_start();
    send_frame(0);
    check("reload_done", done, 1);
    check("reload_err", err, 0);

    // Length overflow: N = MAX_WORDS + 1
    we_count = 0;
    pulse_start();
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    check("ovf_err", err, 1);
    check("ovf_rx_ready", rx_ready, 0);
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    repeat (3) tick();
    rx_valid = 1'b0;
    check("ovf_no_write", we_count, 0);
    check("ovf_err_held", err, 1);

    // Reference image with rx_valid toggling every cycle
    build_frame(2, -1);
    we_count = 0;
    pulse_start();
    send_frame(1);
    check("toggle_done", done, 1);
    check("toggle_we_count", we_count, 2);
    check("toggle_mem0", tb_mem[0], 32'h20080005);
    check("toggle_mem1", tb_mem[1], 32'h21090003);

    // Empty image
    wq = {};
    build_frame(0, -1);
    we_count = 0;
    pulse_start();
    send_frame(0);
    check("empty_done", done, 1);
    check("empty_no_write", we_count, 0);
    check("empty_words", words_loaded, 0);

    // start held high during DATA is ignored
    wq = {};
    for (int i = 0; i < 3; i++) wq.push_back($urandom);
    build_frame(3, -1);
    pulse_start();
    send_range(0, 1, 0);
    start = 1'b1;
    send_range(2, 9, 0);
    start = 1'b0;
    send_range(10, fq.size() - 1, 0);
    check("start_ign_done", done, 1);
    check("start_ign_words", words_loaded, 3);

    // Randomized images
    for (int t = 0; t < 10; t++) begin
      n   = int'($urandom_range(1, 12));
      bad = ($urandom_range(0, 3) == 0);
      gap = int'($urandom_range(0, 2));
      wq  = {};
      for (int i = 0; i < n; i++) wq.push_back($urandom);
      ovr = bad ? int'(xor_words() ^ 8'($urandom_range(1, 255))) : -1;
      build_frame(n, ovr);
      pulse_start();
      send_frame(gap);
      check("rand_done", done, !bad);
      check("rand_err", err, bad);
    end

    // Full capacity image
    wq = {};
    for (int i = 0; i < MAXW; i++) wq.push_back($urandom);
    build_frame(MAXW, -1);
    we_count = 0;
    pulse_start();
    send_frame(0);
    check("full_done", done, 1);
    check("full_last_addr", last_we_addr, MAXW - 1);
    check("full_words", words_loaded, MAXW);
    check("full_we_count", we_count, MAXW);
    check("full_last_word", tb_mem[MAXW-1], wq[MAXW-1]);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
